// File: rtl/muxna1_scan.sv
// muxna1_scan: registered CHANNELS:1 multiplexer with a ready/valid output.
// Direct mode presents one selected channel. Scan mode presents every channel
// in ascending order, one per accepted handshake.
// Build macro MUXNA1_SCAN_MASK_EN adds the ch_mask port. Scan then visits only
// the enabled channels, and a scan start with an all-zero mask is ignored.
module muxna1_scan #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      start,
`ifdef MUXNA1_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic                      busy
);

    // The pointer has one extra bit so that PTR_END (== CHANNELS) is a
    // distinct "no more channels" value, even when CHANNELS is a power of two.
    localparam logic [SEL_W:0] PTR_END = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W:0] PTR_ONE = (SEL_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   ych_q, ych_d;
    logic               valid_q, valid_d;
    logic [SEL_W:0]     ptr_q, ptr_d;

    logic [CHANNELS-1:0] start_mask;
    logic [CHANNELS-1:0] run_mask;
    logic [SEL_W:0]      first_ch;
    logic [SEL_W:0]      next_ch;

    // Lowest enabled channel at or above 'from'. Returns PTR_END when there is none.
    function automatic logic [SEL_W:0] next_en(input logic [CHANNELS-1:0] m,
                                               input logic [SEL_W:0]      from);
        logic [SEL_W:0] r;
        logic           found;
        r     = PTR_END;
        found = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!found && m[i] && (i >= 32'(from))) begin
                found = 1'b1;
                r     = (SEL_W + 1)'(i);
            end
        end
        return r;
    endfunction

    // Channel data at index idx. An index outside the channel range gives zero.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] dv,
                                              input logic [SEL_W:0]            idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(idx) == i) begin
                v = dv[i*WIDTH +: WIDTH];
            end
        end
        return v;
    endfunction

`ifdef MUXNA1_SCAN_MASK_EN
    logic [CHANNELS-1:0] mask_q, mask_d;

    // Capture the mask at scan start, so the channel sequence stays fixed for the whole scan
    always_comb begin
        mask_d = mask_q;
        if ((state_q == ST_IDLE) && start && mode) begin
            mask_d = ch_mask;
        end
    end

    // Mask register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign start_mask = ch_mask;
    assign run_mask   = mask_q;
`else
    assign start_mask = '1;
    assign run_mask   = '1;
`endif

    assign first_ch = next_en(start_mask, '0);
    assign next_ch  = next_en(run_mask, ptr_q);

    // Next-state logic: operation start, output loads and handshake advance
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ych_d   = ych_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!mode) begin
                        y_d     = pick(d, {1'b0, sel});
                        ych_d   = sel;
                        valid_d = 1'b1;
                        state_d = ST_DIRECT;
                    end else if (first_ch != PTR_END) begin
                        y_d     = pick(d, first_ch);
                        ych_d   = first_ch[SEL_W-1:0];
                        valid_d = 1'b1;
                        ptr_d   = first_ch + PTR_ONE;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DIRECT: begin
                if (valid_q && y_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (valid_q && y_ready) begin
                    if (next_ch == PTR_END) begin
                        valid_d = 1'b0;
                        ptr_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        y_d   = pick(d, next_ch);
                        ych_d = next_ch[SEL_W-1:0];
                        ptr_d = next_ch + PTR_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            ych_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ych_q   <= ych_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = ych_q;
    assign y_valid = valid_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muxna1_scan.sv
// tb_muxna1_scan: directed bench for muxna1_scan. A queue-based reference
// model is checked against the DUT on every cycle, and hand-computed literal
// values pin the model itself.
// The mask tests are included when MUXNA1_SCAN_MASK_EN is defined.
module tb_muxna1_scan;

    localparam int CH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic [2:0] sel;
    logic       mode;
    logic       start;
    logic       y_ready;
    logic [0:0] y;
    logic [2:0] y_ch;
    logic       y_valid;
    logic       busy;
`ifdef MUXNA1_SCAN_MASK_EN
    logic [7:0] ch_mask;
    logic [5:0] mask_b;
`endif

    // Second instance, used only for the out-of-range direct select (CHANNELS=6)
    logic [5:0] d_b;
    logic [2:0] sel_b;
    logic       mode_b;
    logic       start_b;
    logic       ready_b;
    logic [0:0] y_b;
    logic [2:0] ych_b;
    logic       valid_b;
    logic       busy_b;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] D_INIT = 8'b0111_0001;

    always #5 clk = ~clk;

    muxna1_scan #(.WIDTH(1), .CHANNELS(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .sel     (sel),
        .mode    (mode),
        .start   (start),
`ifdef MUXNA1_SCAN_MASK_EN
        .ch_mask (ch_mask),
`endif
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    muxna1_scan #(.WIDTH(1), .CHANNELS(6)) u_dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d_b),
        .sel     (sel_b),
        .mode    (mode_b),
        .start   (start_b),
`ifdef MUXNA1_SCAN_MASK_EN
        .ch_mask (mask_b),
`endif
        .y       (y_b),
        .y_ch    (ych_b),
        .y_valid (valid_b),
        .y_ready (ready_b),
        .busy    (busy_b)
    );

    // Reference model. An operation is a queue of channel indices still to be
    // presented, and data is taken from d at the edge where it is presented.
    bit   m_busy  = 1'b0;
    bit   m_valid = 1'b0;
    logic m_y     = 1'b0;
    int   m_ch    = 0;
    int   pend[$];

    always begin
        logic [7:0] msk;
        @(posedge clk or negedge rst_n);
`ifdef MUXNA1_SCAN_MASK_EN
        msk = ch_mask;
`else
        msk = 8'hFF;
`endif
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_y     = 1'b0;
            m_ch    = 0;
            pend.delete();
        end else if (m_busy) begin
            if (y_ready) begin
                if (pend.size() == 0) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b0;
                end else begin
                    m_ch = pend.pop_front();
                    m_y  = d[m_ch];
                end
            end
        end else if (start) begin
            if (!mode) begin
                m_ch    = int'(sel);
                m_y     = (int'(sel) < CH) ? d[sel] : 1'b0;
                m_valid = 1'b1;
                m_busy  = 1'b1;
            end else begin
                for (int i = 0; i < CH; i++) begin
                    if (msk[i]) pend.push_back(i);
                end
                if (pend.size() != 0) begin
                    m_ch    = pend.pop_front();
                    m_y     = d[m_ch];
                    m_valid = 1'b1;
                    m_busy  = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and compare the DUT against the model just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        chk("model_valid", 32'(y_valid), 32'(m_valid));
        chk("model_busy", 32'(busy), 32'(m_busy));
        if (m_valid) begin
            chk("model_y", 32'(y), 32'(m_y));
            chk("model_y_ch", 32'(y_ch), 32'(m_ch));
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit && busy; k++) tick();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int ey[8];
        int nbusy;
        ey = '{1, 0, 0, 0, 1, 1, 1, 0};

        rst_n   = 1'b1;
        d       = D_INIT;
        sel     = '0;
        mode    = 1'b0;
        start   = 1'b0;
        y_ready = 1'b1;
`ifdef MUXNA1_SCAN_MASK_EN
        ch_mask = 8'hFF;
        mask_b  = 6'h3F;
`endif
        d_b     = 6'b11_1111;
        sel_b   = '0;
        mode_b  = 1'b0;
        start_b = 1'b0;
        ready_b = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_y_ch", 32'(y_ch), 32'd0);
        chk("rst_valid", 32'(y_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        tick();

        // Direct, sel=4
        sel = 3'd4; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dir_y", 32'(y), 32'd1);
        chk("dir_y_ch", 32'(y_ch), 32'd4);
        chk("dir_valid", 32'(y_valid), 32'd1);
        tick();
        chk("dir_done_valid", 32'(y_valid), 32'd0);
        chk("dir_done_busy", 32'(busy), 32'd0);

        // Full scan, y_ready held high
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            chk("scan_y", 32'(y), 32'(ey[i]));
            chk("scan_y_ch", 32'(y_ch), 32'(i));
            if (busy) nbusy++;
            if (i < 7) tick();
        end
        chk("scan_busy_cycles", 32'(nbusy), 32'd8);
        tick();
        chk("scan_end_busy", 32'(busy), 32'd0);
        chk("scan_end_valid", 32'(y_valid), 32'd0);

        // Scan stalled at ch2 while d toggles
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("stall_at_ch2", 32'(y_ch), 32'd2);
        y_ready = 1'b0;
        d = ~D_INIT;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_y", 32'(y), 32'd0);
            chk("stall_y_ch", 32'(y_ch), 32'd2);
        end
        d = D_INIT;
        y_ready = 1'b1;
        tick();
        chk("resume_y_ch", 32'(y_ch), 32'd3);
        chk("resume_y", 32'(y), 32'd0);
        wait_idle(20);

        // Reset in the middle of a scan
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_y_ch", 32'(y_ch), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(y_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_valid", 32'(y_valid), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end

        // Start held through the final handshake is ignored for that cycle
        sel = 3'd0; mode = 1'b0; start = 1'b1;
        tick();
        chk("hs_first_y", 32'(y), 32'd1);
        sel = 3'd5;
        tick();
        chk("hs_ignored_valid", 32'(y_valid), 32'd0);
        chk("hs_ignored_busy", 32'(busy), 32'd0);
        tick();
        chk("hs_next_valid", 32'(y_valid), 32'd1);
        chk("hs_next_y_ch", 32'(y_ch), 32'd5);
        start = 1'b0;
        tick();

        // Direct sweep over every channel
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s); mode = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            wait_idle(5);
        end

        // Scan with an irregular y_ready pattern
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 80 && busy; k++) begin
            y_ready = 1'($urandom_range(0, 1));
            tick();
        end
        y_ready = 1'b1;
        wait_idle(5);

        // CHANNELS=6: an out-of-range select gives zero data
        sel_b = 3'd7; mode_b = 1'b0; start_b = 1'b1; ready_b = 1'b0;
        tick();
        start_b = 1'b0;
        chk("c6_sel7_y", 32'(y_b), 32'd0);
        chk("c6_sel7_y_ch", 32'(ych_b), 32'd7);
        chk("c6_sel7_valid", 32'(valid_b), 32'd1);
        ready_b = 1'b1;
        tick();
        chk("c6_sel7_done", 32'(valid_b), 32'd0);
        sel_b = 3'd5; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("c6_sel5_y", 32'(y_b), 32'd1);
        tick();

`ifdef MUXNA1_SCAN_MASK_EN
        // Masked scan over channels 4..7
        ch_mask = 8'hF0; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 4; i < 8; i++) begin
            chk("mask_y_ch", 32'(y_ch), 32'(i));
            chk("mask_y", 32'(y), 32'(ey[i]));
            if (i < 7) tick();
        end
        tick();
        chk("mask_end_busy", 32'(busy), 32'd0);
        // An all-zero mask ignores the scan start
        ch_mask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mask0_busy", 32'(busy), 32'd0);
        chk("mask0_valid", 32'(y_valid), 32'd0);
        // Direct mode ignores the mask
        mode = 1'b0; sel = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mask0_direct_valid", 32'(y_valid), 32'd1);
        chk("mask0_direct_y", 32'(y), 32'd1);
        wait_idle(5);
        ch_mask = 8'hFF;
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
